uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Byte-level program loader between the UART RX stage and the core/memory pair.
- Parses framed commands from the RX byte stream and assembles 32-bit words.
- Issues single-cycle memory writes on the shared write/operand/operand_addr bus.
- Holds the core in reset while loading and returns ACK/NAK bytes through the TX valid/ready handshake.

Parameters:
- word_width, 32, memory word width; must be 32 (4 data bytes per frame).
- addr_width, 5, memory address width.
- CLK_FREQ, 50000000, clock frequency in Hz.
- TIMEOUT_CYCLES, CLK_FREQ/100, maximum idle clocks between bytes inside a frame before the frame is abandoned.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- rx_data  input  8  byte from RX; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle pulse per received byte.
- tx_data  output  8  response byte to TX.
- tx_valid  output  1  response pending; held until accepted.
- tx_ready  input  1  TX can accept; transfer occurs when tx_valid && tx_ready.
- write  output  1  one-cycle memory write strobe.
- operand  output  word_width  write data.
- operand_addr  output  addr_width  write address.
- core_reset  output  1  1 = core held in reset.
- busy  output  1  1 while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (reset=0 at a clk edge) forces the following, from any state including mid-frame and mid-response:
  - state = IDLE; core_reset = 1.
  - write, tx_valid, busy = 0; operand, operand_addr, tx_data = 0.
  - checksum and timeout counter = 0.
  - A pending response is discarded.
- Frame format (load): 0xA5, ADDR, D0, D1, D2, D3, CSUM.
  - D0 is the LSB: operand = {D3, D2, D1, D0}.
  - CSUM = ADDR ^ D0 ^ D1 ^ D2 ^ D3 (header excluded).
- Run command: single byte 0x5A received in IDLE.
- States:
  - IDLE:
    - rx 0xA5 -> core_reset <= 1, clear checksum, go to ADDR.
    - rx 0x5A -> core_reset <= 0, tx_data <= 0x06, go to RESP.
    - Any other byte is ignored; stay in IDLE.
  - ADDR: on rx, latch the address byte, checksum ^= byte, go to DATA with byte index 0.
  - DATA: on rx, shift the byte into the word at the current index, checksum ^= byte. After the 4th byte, go to CSUM.
  - CSUM:
    - On rx, if byte == checksum AND address byte[7:addr_width] == 0 -> go to WRITE.
    - Otherwise tx_data <= 0x15 (NAK), go to RESP.
  - WRITE: one cycle, then tx_data <= 0x06, go to RESP.
    - write = 1.
    - operand = assembled word.
    - operand_addr = address byte[addr_width-1:0].
  - RESP:
    - tx_valid = 1, tx_data stable.
    - On tx_valid && tx_ready -> tx_valid <= 0, go to IDLE.
    - tx_valid must not drop before acceptance.
- Latency:
  - CSUM byte sampled at edge N -> write high for exactly the cycle after edge N+1 (one cycle only).
  - ACK: tx_valid rises at edge N+2.
  - NAK: tx_valid rises at edge N+1.
  - 0x5A sampled at edge N -> core_reset = 0 and tx_valid = 1 after edge N+1.
- Write bus: write = 0 outside WRITE; operand/operand_addr hold their last values.
- Timeout:
  - In ADDR/DATA/CSUM, the counter clears on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 -> go to IDLE: no write, no response; core_reset stays 1.
- Bytes arriving while in WRITE or RESP are dropped (not queued).
- 0xA5 / 0x5A bytes inside a frame are treated as payload, not as commands.
- core_reset, once set by 0xA5, stays 1 through NAK and timeout until a later 0x5A.

Test Plan:
- Reset then A5 03 78 56 34 12 (CSUM 0x03^0x78^0x56^0x34^0x12 = 0x0B) 0B -> one write pulse; operand=0x12345678, operand_addr=3; tx 0x06 accepted with tx_ready=1; core_reset=1 throughout.
- Same frame with CSUM 0x0C -> no write; tx_data=0x15; state returns to IDLE after acceptance.
- A5 20 00 00 00 00 20 (address out of range) -> NAK 0x15, no write.
- 0x5A in IDLE with tx_ready held 0 for 10 cycles -> core_reset=0 next cycle; tx_valid=1 with tx_data=0x06 stable for all 10 cycles; cleared one cycle after tx_ready=1.
- A5 01 then no bytes for TIMEOUT_CYCLES (bench sets 100) -> busy drops to 0, no write, no tx_valid; a following full frame succeeds normally.
- reset=0 asserted during DATA and during RESP (tx_valid=1) -> next cycle all outputs at reset values, core_reset=1, tx_valid=0; later frames process correctly.

Source files
------------

// File: rtl/uart_loader.sv
// Byte-stream program loader: parses A5-framed word loads and the 5A run command,
// drives single-cycle memory writes, holds the core in reset and answers ACK/NAK.
module uart_loader #(
    parameter int unsigned word_width     = 32,
    parameter int unsigned addr_width     = 5,
    parameter int unsigned CLK_FREQ       = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  write,
    output logic [word_width-1:0] operand,
    output logic [addr_width-1:0] operand_addr,
    output logic                  core_reset,
    output logic                  busy
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0]  Ack    = 8'h06;
    localparam logic [7:0]  Nak    = 8'h15;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StCsum, StWrite, StResp} state_e;

    state_e                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic [word_width-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [1:0]            idx_q, idx_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  core_reset_q, core_reset_d;
    logic                  write_q, write_d;
    logic [word_width-1:0] operand_q, operand_d;
    logic [addr_width-1:0] operand_addr_q, operand_addr_d;
    logic                  timed_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            idx_q          <= '0;
            timer_q        <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            core_reset_q   <= 1'b1;
            write_q        <= 1'b0;
            operand_q      <= '0;
            operand_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            core_reset_q   <= core_reset_d;
            write_q        <= write_d;
            operand_q      <= operand_d;
            operand_addr_q <= operand_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        word_d         = word_q;
        csum_d         = csum_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = 1'b0;
        core_reset_d   = core_reset_q;
        write_d        = 1'b0;
        operand_d      = operand_q;
        operand_addr_d = operand_addr_q;
        timed_out      = 1'b0;

        // Inter-byte watchdog, only armed while a frame is being received.
        if (state_q inside {StAddr, StData, StCsum}) begin
            if (rx_valid) begin
                timer_d = '0;
            end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                timer_d   = '0;
                timed_out = 1'b1;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == 8'hA5) begin
                    core_reset_d = 1'b1;
                    csum_d       = '0;
                    timer_d      = '0;
                    state_d      = StAddr;
                end else if (rx_valid && rx_data == 8'h5A) begin
                    core_reset_d = 1'b0;
                    tx_data_d    = Ack;
                    state_d      = StResp;
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    addr_d  = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (rx_valid) begin
                    word_d[{idx_q, 3'b000} +: 8] = rx_data;
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = StCsum;
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    if (rx_data == csum_q && (addr_q >> addr_width) == 8'd0) begin
                        state_d = StWrite;
                    end else begin
                        tx_data_d = Nak;
                        state_d   = StResp;
                    end
                end
            end
            StWrite: begin
                write_d        = 1'b1;
                operand_d      = word_q;
                operand_addr_d = addr_q[addr_width-1:0];
                tx_data_d      = Ack;
                state_d        = StResp;
            end
            StResp: begin
                // tx_valid rises one cycle after entry and holds until accepted.
                if (tx_valid_q && tx_ready) begin
                    state_d = StIdle;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timed_out) state_d = StIdle;
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign write        = write_q;
    assign operand      = operand_q;
    assign operand_addr = operand_addr_q;
    assign core_reset   = core_reset_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_loader.sv
// Directed plus randomized frame stimulus for uart_loader, checked against a
// frame-level model of expected writes and ACK/NAK responses.
module tb_uart_loader;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        write;
    logic [31:0] operand;
    logic [4:0]  operand_addr;
    logic        core_reset;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int exp_wr = 0;

    uart_loader #(
        .word_width    (32),
        .addr_width    (5),
        .CLK_FREQ      (50000000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .write       (write),
        .operand     (operand),
        .operand_addr(operand_addr),
        .core_reset  (core_reset),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write) wr_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_write"}, write, 1'b0);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_core_reset"}, core_reset, 1'b1);
        check({tag, "_operand"}, operand, 32'h0);
        check({tag, "_operand_addr"}, operand_addr, 5'h0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
    endtask

    // Model: a frame is accepted iff its checksum matches and the address fits.
    task automatic do_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
        logic [7:0] ref_cs;
        logic       ok;
        ref_cs = a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        ok     = (cs == ref_cs) && (a < 8'd32);
        send_byte(8'hA5);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        send_byte(cs);
        check("frame_busy", busy, 1'b1);
        check("frame_no_early_write", write, 1'b0);
        if (ok) begin
            tick();
            check("ack_write", write, 1'b1);
            check("ack_operand", operand, d);
            check("ack_addr", operand_addr, a[4:0]);
            check("ack_tx_not_yet", tx_valid, 1'b0);
            exp_wr++;
            tick();
            check("ack_write_drop", write, 1'b0);
            check("ack_tx_valid", tx_valid, 1'b1);
            check("ack_tx_data", tx_data, 8'h06);
        end else begin
            tick();
            check("nak_no_write", write, 1'b0);
            check("nak_tx_valid", tx_valid, 1'b1);
            check("nak_tx_data", tx_data, 8'h15);
        end
        check("frame_core_reset", core_reset, 1'b1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("resp_accepted", tx_valid, 1'b0);
        check("resp_idle", busy, 1'b0);
        check("write_count", wr_pulses, exp_wr);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [7:0]  rc;
        logic [7:0]  noise;
        int          n;

        reset = 1'b0;
        repeat (3) tick();
        check_reset_state("por");
        reset = 1'b1;
        tick();

        // Directed frames: good, bad checksum, out-of-range address, command bytes as payload.
        do_frame(8'h03, 32'h12345678, 8'h0B);
        do_frame(8'h03, 32'h12345678, 8'h0C);
        do_frame(8'h20, 32'h00000000, 8'h20);
        do_frame(8'h07, 32'hA55AA55A, 8'h07);
        do_frame(8'h1F, 32'hDEADBEEF, 8'h1F ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);

        // Run command with TX back-pressure; a byte arriving during RESP is dropped.
        send_byte(8'h5A);
        check("run_core_reset", core_reset, 1'b0);
        tick();
        check("run_tx_valid", tx_valid, 1'b1);
        check("run_tx_data", tx_data, 8'h06);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) send_byte(8'hA5);
            else tick();
            check("run_hold_valid", tx_valid, 1'b1);
            check("run_hold_data", tx_data, 8'h06);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("run_accepted", tx_valid, 1'b0);
        check("run_dropped_byte", busy, 1'b0);
        check("run_core_free", core_reset, 1'b0);

        // Inter-byte timeout abandons the frame silently.
        send_byte(8'hA5);
        send_byte(8'h01);
        check("to_busy", busy, 1'b1);
        n = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            if (!busy) break;
            tick();
            n++;
        end
        check("to_window", (n >= TO - 1 && n <= TO + 1), 1'b1);
        check("to_no_tx", tx_valid, 1'b0);
        check("to_no_write", wr_pulses, exp_wr);
        check("to_core_reset", core_reset, 1'b1);
        do_frame(8'h0A, 32'hCAFEF00D, 8'h0A ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);

        // Reset mid-DATA.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_state("rst_data");
        tick();

        // Reset while a response is pending.
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'h33);
        send_byte(8'hFF);
        tick();
        check("rst_resp_pending", tx_valid, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_state("rst_resp");
        tick();
        check("rst_resp_stays_idle", tx_valid, 1'b0);
        do_frame(8'h03, 32'h12345678, 8'h0B);

        // Randomized frames with idle noise and occasional corrupted checksums.
        for (int k = 0; k < 24; k++) begin
            noise = 8'($urandom);
            if (noise != 8'hA5 && noise != 8'h5A) begin
                send_byte(noise);
                check("noise_ignored", busy, 1'b0);
            end
            ra = 8'($urandom_range(0, 47));
            rd = $urandom;
            rc = ra ^ rd[7:0] ^ rd[15:8] ^ rd[23:16] ^ rd[31:24];
            if ($urandom_range(0, 3) == 0) rc = rc ^ (8'h01 << $urandom_range(0, 7));
            do_frame(ra, rd, rc);
        end

        check("final_write_count", wr_pulses, exp_wr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
